// File: rtl/lzd_pkg.sv
// Shared helpers for the leading-zero/leading-one normaliser.
//   clog2        : ceiling log2 usable in constant expressions
//   pad_width    : tree width, operand width rounded up to a power of two
//   tree_levels  : number of pairwise levels in the tree (log2 of pad_width)
//   split_level  : level at which the three-stage pipeline cuts the tree
//   count_width  : bits needed to hold a count of 0..DW
//   pipe_ok      : legal range check for the stage count
package lzd_pkg;

    localparam int PIPE_MIN = 1;
    localparam int PIPE_MAX = 3;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    function automatic int pad_width(input int dw);
        return 1 << clog2(dw);
    endfunction

    function automatic int tree_levels(input int dw);
        return clog2(dw);
    endfunction

    function automatic int split_level(input int dw);
        return (clog2(dw) + 1) / 2;
    endfunction

    function automatic int count_width(input int dw);
        return clog2(dw + 1);
    endfunction

    function automatic bit pipe_ok(input int p);
        return (p >= PIPE_MIN) && (p <= PIPE_MAX);
    endfunction

endpackage

// File: rtl/lzd_tree.sv
// Combinational pairwise leading-terminator tree, levels START..STOP.
// A node at level k covers 2^k input bits and carries:
//   v : a terminating (set) bit exists somewhere in the group
//   p : leading count inside the group (k bits, kept in the low bits of an
//       L-bit field so every level uses the same storage width)
// Index order: higher node index = more significant bits.
// Ports:
//   v_in  : node valid bits at level START   (PW >> START nodes)
//   p_in  : node counts at level START, L bits per node
//   v_out : node valid bits at level STOP    (PW >> STOP nodes)
//   p_out : node counts at level STOP, L bits per node
module lzd_tree #(
    parameter int PW    = 64,
    parameter int L     = 6,
    parameter int START = 0,
    parameter int STOP  = 6
) (
    input  logic [(PW >> START)-1:0]     v_in,
    input  logic [(PW >> START)*L-1:0]   p_in,
    output logic [(PW >> STOP)-1:0]      v_out,
    output logic [(PW >> STOP)*L-1:0]    p_out
);

    localparam int NIN  = PW >> START;
    localparam int NOUT = PW >> STOP;
    localparam int NL   = STOP - START;

    logic [PW-1:0] v_l [0:NL];
    logic [L-1:0]  p_l [0:NL][0:PW-1];

    always_comb begin
        logic         hi_v;
        logic [L-1:0] p_t;
        hi_v = 1'b0;
        p_t  = '0;
        for (int k = 0; k <= NL; k++) begin
            v_l[k] = '0;
            for (int i = 0; i < PW; i++) p_l[k][i] = '0;
        end
        for (int i = 0; i < NIN; i++) begin
            v_l[0][i] = v_in[i];
            p_l[0][i] = p_in[i*L +: L];
        end
        for (int k = 0; k < NL; k++) begin
            for (int j = 0; j < PW / 2; j++) begin
                if (j < (PW >> (START + k + 1))) begin
                    hi_v = v_l[k][2*j+1];
                    v_l[k+1][j] = hi_v | v_l[k][2*j];
                    // Upper half terminates: count comes from it alone.
                    // Otherwise the whole upper half (2^level bits) is leading.
                    p_t = hi_v ? p_l[k][2*j+1] : p_l[k][2*j];
                    p_t[START+k] = ~hi_v;
                    p_l[k+1][j] = p_t;
                end
            end
        end
        for (int i = 0; i < NOUT; i++) begin
            v_out[i]         = v_l[NL][i];
            p_out[i*L +: L]  = p_l[NL][i];
        end
    end

endmodule

// File: rtl/lzd_norm_pipe.sv
// Pipelined leading-zero / leading-one detector with left normaliser.
// One operand per cycle under valid/ready; result after exactly PIPE cycles
// when the output is not stalled.
// Ports:
//   clk, reset            : clock, asynchronous active-high reset
//   scan_in0, scan_en,
//   test_mode, scan_out0  : DFT hooks, not used by the logic (scan_out0 = 0)
//   in_valid/in_ready     : operand handshake
//   din, lo_mode, tag_in  : operand, 1 = count leading ones, sideband tag
//   out_valid/out_ready   : result handshake
//   numz                  : leading count 0..DW
//   dout                  : din << numz, zero filled
//   zero                  : no terminating bit (numz == DW)
//   tag_out               : tag of this result
// Handshake: a transfer happens on a cycle where valid and ready are both 1.
// The whole pipe advances together (adv = ~out_valid | out_ready); in_ready
// is adv, so bubbles never block acceptance while the output drains.
module lzd_norm_pipe
    import lzd_pkg::*;
#(
    parameter int DW   = 48,
    parameter int CW   = $clog2(DW + 1),
    parameter int PIPE = 2,
    parameter int TAGW = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            scan_in0,
    input  logic            scan_en,
    input  logic            test_mode,
    output logic            scan_out0,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [DW-1:0]   din,
    input  logic            lo_mode,
    input  logic [TAGW-1:0] tag_in,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [CW-1:0]   numz,
    output logic [DW-1:0]   dout,
    output logic            zero,
    output logic [TAGW-1:0] tag_out
);

    localparam int PW = pad_width(DW);
    localparam int L  = tree_levels(DW);
    localparam int M  = split_level(DW);
    localparam int NM = PW >> M;

    logic unused_scan;
    assign unused_scan = ^{scan_in0, scan_en, test_mode};
    assign scan_out0   = 1'b0;

    logic adv;
    logic out_valid_q, out_valid_d;
    logic [CW-1:0]   numz_q, numz_d;
    logic [DW-1:0]   dout_q, dout_d;
    logic            zero_q, zero_d;
    logic [TAGW-1:0] tag_q, tag_d;

    assign adv      = ~out_valid_q | out_ready;
    assign in_ready = adv;

    // Operand (inverted for leading-one mode) in the MSBs, padding ones below
    // so the count saturates at DW whenever PW > DW.
    logic [PW-1:0] tree_in;
    always_comb begin
        tree_in = '1;
        tree_in[PW-1 -: DW] = din ^ {DW{lo_mode}};
    end

    // Last pre-output stage: count + original operand ready for the shifter.
    logic            fin_valid;
    logic [CW-1:0]   fin_numz;
    logic [DW-1:0]   fin_din;
    logic [TAGW-1:0] fin_tag;

    if (!pipe_ok(PIPE)) begin : g_bad
        $error("lzd_norm_pipe: PIPE must be 1..3");
        assign fin_valid = 1'b0;
        assign fin_numz  = '0;
        assign fin_din   = '0;
        assign fin_tag   = '0;
    end else if (PIPE == 1) begin : g_p1
        logic         root_v;
        logic [L-1:0] root_p;
        lzd_tree #(.PW(PW), .L(L), .START(0), .STOP(L)) u_tree (
            .v_in (tree_in),
            .p_in ('0),
            .v_out(root_v),
            .p_out(root_p)
        );
        // root_v can only be 0 when PW == DW and the operand has no terminator.
        assign fin_valid = in_valid;
        assign fin_numz  = root_v ? CW'(root_p) : CW'(DW);
        assign fin_din   = din;
        assign fin_tag   = tag_in;
    end else if (PIPE == 2) begin : g_p2
        logic         root_v;
        logic [L-1:0] root_p;
        logic            s1_valid_q, s1_valid_d;
        logic [CW-1:0]   s1_numz_q, s1_numz_d;
        logic [DW-1:0]   s1_din_q, s1_din_d;
        logic [TAGW-1:0] s1_tag_q, s1_tag_d;

        lzd_tree #(.PW(PW), .L(L), .START(0), .STOP(L)) u_tree (
            .v_in (tree_in),
            .p_in ('0),
            .v_out(root_v),
            .p_out(root_p)
        );

        always_comb begin
            s1_valid_d = s1_valid_q;
            s1_numz_d  = s1_numz_q;
            s1_din_d   = s1_din_q;
            s1_tag_d   = s1_tag_q;
            if (adv) begin
                s1_valid_d = in_valid;
                s1_numz_d  = root_v ? CW'(root_p) : CW'(DW);
                s1_din_d   = din;
                s1_tag_d   = tag_in;
            end
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                s1_valid_q <= 1'b0;
                s1_numz_q  <= '0;
                s1_din_q   <= '0;
                s1_tag_q   <= '0;
            end else begin
                s1_valid_q <= s1_valid_d;
                s1_numz_q  <= s1_numz_d;
                s1_din_q   <= s1_din_d;
                s1_tag_q   <= s1_tag_d;
            end
        end

        assign fin_valid = s1_valid_q;
        assign fin_numz  = s1_numz_q;
        assign fin_din   = s1_din_q;
        assign fin_tag   = s1_tag_q;
    end else begin : g_p3
        logic [NM-1:0]   mid_v;
        logic [NM*L-1:0] mid_p;
        logic            root_v;
        logic [L-1:0]    root_p;
        logic            ma_valid_q, ma_valid_d;
        logic [NM-1:0]   ma_v_q, ma_v_d;
        logic [NM*L-1:0] ma_p_q, ma_p_d;
        logic [DW-1:0]   ma_din_q, ma_din_d;
        logic [TAGW-1:0] ma_tag_q, ma_tag_d;
        logic            s2_valid_q, s2_valid_d;
        logic [CW-1:0]   s2_numz_q, s2_numz_d;
        logic [DW-1:0]   s2_din_q, s2_din_d;
        logic [TAGW-1:0] s2_tag_q, s2_tag_d;

        // Tree cut at level M: the p/v vectors of that level are registered.
        lzd_tree #(.PW(PW), .L(L), .START(0), .STOP(M)) u_tree_lo (
            .v_in (tree_in),
            .p_in ('0),
            .v_out(mid_v),
            .p_out(mid_p)
        );

        lzd_tree #(.PW(PW), .L(L), .START(M), .STOP(L)) u_tree_hi (
            .v_in (ma_v_q),
            .p_in (ma_p_q),
            .v_out(root_v),
            .p_out(root_p)
        );

        always_comb begin
            ma_valid_d = ma_valid_q;
            ma_v_d     = ma_v_q;
            ma_p_d     = ma_p_q;
            ma_din_d   = ma_din_q;
            ma_tag_d   = ma_tag_q;
            s2_valid_d = s2_valid_q;
            s2_numz_d  = s2_numz_q;
            s2_din_d   = s2_din_q;
            s2_tag_d   = s2_tag_q;
            if (adv) begin
                ma_valid_d = in_valid;
                ma_v_d     = mid_v;
                ma_p_d     = mid_p;
                ma_din_d   = din;
                ma_tag_d   = tag_in;
                s2_valid_d = ma_valid_q;
                s2_numz_d  = root_v ? CW'(root_p) : CW'(DW);
                s2_din_d   = ma_din_q;
                s2_tag_d   = ma_tag_q;
            end
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                ma_valid_q <= 1'b0;
                ma_v_q     <= '0;
                ma_p_q     <= '0;
                ma_din_q   <= '0;
                ma_tag_q   <= '0;
                s2_valid_q <= 1'b0;
                s2_numz_q  <= '0;
                s2_din_q   <= '0;
                s2_tag_q   <= '0;
            end else begin
                ma_valid_q <= ma_valid_d;
                ma_v_q     <= ma_v_d;
                ma_p_q     <= ma_p_d;
                ma_din_q   <= ma_din_d;
                ma_tag_q   <= ma_tag_d;
                s2_valid_q <= s2_valid_d;
                s2_numz_q  <= s2_numz_d;
                s2_din_q   <= s2_din_d;
                s2_tag_q   <= s2_tag_d;
            end
        end

        assign fin_valid = s2_valid_q;
        assign fin_numz  = s2_numz_q;
        assign fin_din   = s2_din_q;
        assign fin_tag   = s2_tag_q;
    end

    // Output stage: shifter. A shift by DW clears dout, covering zero = 1.
    always_comb begin
        out_valid_d = out_valid_q;
        numz_d      = numz_q;
        dout_d      = dout_q;
        zero_d      = zero_q;
        tag_d       = tag_q;
        if (adv) begin
            out_valid_d = fin_valid;
            numz_d      = fin_numz;
            dout_d      = fin_din << fin_numz;
            zero_d      = (fin_numz == CW'(DW));
            tag_d       = fin_tag;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            numz_q      <= '0;
            dout_q      <= '0;
            zero_q      <= 1'b0;
            tag_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            numz_q      <= numz_d;
            dout_q      <= dout_d;
            zero_q      <= zero_d;
            tag_q       <= tag_d;
        end
    end

    assign out_valid = out_valid_q;
    assign numz      = numz_q;
    assign dout      = dout_q;
    assign zero      = zero_q;
    assign tag_out   = tag_q;

endmodule

// File: doc/lzd_norm_pipe.md
Name: lzd_norm_pipe

Overview:
Parametrised, pipelined leading-zero/leading-one detector with integrated left-normaliser, for the fixed-point log/sqrt datapaths of the Box-Muller generator. Accepts one operand per cycle under valid/ready flow control. Returns the count, the normalised operand, an all-zero flag and a pass-through tag after a fixed PIPE-cycle latency.

Parameters:
DW, 48, operand width (2..64); tree internally padded with ones up to next power of two PW
CW, $clog2(DW+1), count width (6 for DW=48)
PIPE, 2, register stages, 1..3; equals latency in cycles
TAGW, 4, sideband tag width passed through unchanged

Ports:
clk  in  1  system clock
reset  in  1  asynchronous active-high reset
scan_in0  in  1  test scan data in (DFT-stitched; unused in RTL)
scan_en  in  1  test scan enable (unused in RTL)
test_mode  in  1  test mode select (unused in RTL)
scan_out0  out  1  test scan data out; RTL drives 0
in_valid  in  1  operand valid
in_ready  out  1  block can accept operand this cycle
din  in  DW  operand
lo_mode  in  1  0 = count leading zeros, 1 = count leading ones
tag_in  in  TAGW  sideband
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
numz  out  CW  leading count, 0..DW
dout  out  DW  din shifted left by numz, zero-filled
zero  out  1  no terminating bit found (count == DW)
tag_out  out  TAGW  tag of this result

Behaviour:
- Reset: asynchronous, active-high; all stage valid bits, out_valid, numz, dout, zero and tag_out clear to 0 immediately. In-flight operands are discarded.
- Reset mid-operation: no partial result is ever presented after reset.
- Global advance: adv = ~out_valid | out_ready. All stages shift when adv = 1 and hold otherwise; in_ready = adv (combinational).
- Transfer rules: accept when in_valid & in_ready. Output handshake completes on out_valid & out_ready.
- Bubbles: bubbles propagate as valid = 0 entries and never block acceptance while the output is drained.
- Stalls: out_ready low while out_valid = 1 freezes every stage. Outputs stay stable until accepted.
- Throughput and latency: one result per cycle with no stalls. Result appears exactly PIPE cycles after acceptance.
- Stage split, PIPE=1: tree and shifter in one stage.
- Stage split, PIPE=2: stage 1 registers count + operand; stage 2 performs the shift.
- Stage split, PIPE=3: stage 1 registers the tree half-way (level ceil(L/2), L=log2 PW: p/v vectors); stage 2 completes the count; stage 3 shifts.
- Leading-one mode: operand is bitwise inverted before the tree when lo_mode = 1. Shift always applies to the original din.
- Count derivation: pairwise tree. Each level emits v = OR of halves, and p = {~v_hi, v_hi ? p_hi : p_lo}. Padding bits are ones, so count saturates at DW.
- zero = (numz == DW). On zero, dout = 0 for both modes (shift by DW).
- Example: din = all ones with lo_mode = 1 gives numz = DW, zero = 1.
- MSB terminator: a terminating bit in the MSB gives numz = 0 and dout = din.
- Sideband: lo_mode and tag travel with their operand through every stage.

Decomposition:
- lzd_pkg: clog2 function, PW/CW/level-count derivations, PIPE range check constant.
- Sub-module lzd_tree: generic combinational pairwise tree. Parameters are width and level range (start/stop), so the PIPE=3 split instantiates it twice.
- The shifter stays inline in lzd_norm_pipe.

Test Plan:
- DW=48, PIPE=2, lo_mode=0, din=48'h0000_0100_0000, out_ready=1 -> 2 cycles later numz=23, dout=48'h8000_0000_0000, zero=0.
- din=0, lo_mode=0 -> numz=48, zero=1, dout=0. din=48'hFFFF_FFFF_FFF0, lo_mode=1 -> numz=44, dout=0.
- Back-to-back stream of 100 random operands with random tags, out_ready=1 -> one result per cycle, in order, matching reference model; tags intact.
- Hold out_ready=0 for 5 cycles with pipe full -> in_ready=0, outputs stable, no loss or duplication; release -> remaining results drain in order.
- Assert reset with 2 operands in flight -> out_valid=0 and numz/dout/tag_out=0 within the same cycle; no stale result after release.
- Repeat the random stream for PIPE=1 and PIPE=3, and for DW=17 -> latency equals PIPE; numz ranges 0..17 with saturation at 17.
